// File: rtl/banner_overlay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// banner_overlay : 1bpp ROM bitmap overlay with drop-in slide and blinking FG
// Rev 1.0
// ----------------------------------------------------------------------------
module banner_overlay #(
  parameter int          X0           = 350,
  parameter int          Y0           = 100,
  parameter int          W            = 740,
  parameter int          H            = 650,
  parameter int          ADDR_W       = 19,
  parameter int          ROM_LAT      = 1,
  parameter int          BLINK_FRAMES = 31,
  parameter int          SLIDE_STEP   = 8,
  parameter logic [11:0] BG_COLOR     = 12'h7CC,
  parameter logic [11:0] FG_A         = 12'h104,
  parameter logic [11:0] FG_B         = 12'hF73
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       pos_x,
  input  logic [10:0]       pos_y,
  input  logic              frame_tick,
  input  logic              show,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic [3:0]        ovl_r,
  output logic [3:0]        ovl_g,
  output logic [3:0]        ovl_b,
  output logic              ovl_active,
  output logic              anim_done
);

  localparam logic [11:0] c_y_top  = 12'(Y0);
  localparam logic [11:0] c_y_end  = 12'(Y0 + H);
  localparam logic [11:0] c_x_lft  = 12'(X0);
  localparam logic [11:0] c_x_end  = 12'(X0 + W);
  localparam logic [11:0] c_step   = 12'(SLIDE_STEP);
  localparam logic [15:0] c_bf     = 16'(BLINK_FRAMES);
  localparam logic [15:0] c_bwrap  = 16'(2 * BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'd0,
    ST_SLIDE  = 2'd1,
    ST_SHOWN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [11:0]         r_off;
  logic [15:0]         r_blink;
  logic                r_done;
  logic                r_in0;
  logic [11:0]         r_row;
  logic [11:0]         r_col;
  logic [ADDR_W-1:0]   r_addr;
  logic [ROM_LAT:0]    r_vld;
  logic [11:0]         r_rgb;
  logic                r_act;

  logic [15:0]         w_blink_nxt;
  logic [11:0]         w_ys;
  logic [11:0]         w_xs;
  logic                w_in;
  logic [ADDR_W-1:0]   w_addr;
  logic [11:0]         w_fg;
  logic [11:0]         w_pix;

  assign w_blink_nxt = (BLINK_FRAMES == 0 || r_blink == c_bwrap) ? 16'd0 : r_blink + 16'd1;

  // show=0 wins over everything, including a coincident frame_tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HIDDEN;
      r_off   <= c_y_end;
      r_blink <= '0;
      r_done  <= 1'b0;
    end else if (!show) begin
      r_state <= ST_HIDDEN;
      r_off   <= c_y_end;
      r_blink <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_HIDDEN: begin
          r_blink <= '0;
          if (SLIDE_STEP == 0) begin
            r_state <= ST_SHOWN;
            r_off   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_SLIDE;
            r_off   <= c_y_end;
          end
        end
        ST_SLIDE: begin
          if (frame_tick) begin
            r_blink <= w_blink_nxt;
            if (r_off <= c_step) begin
              r_off   <= '0;
              r_state <= ST_SHOWN;
              r_done  <= 1'b1;
            end else begin
              r_off <= r_off - c_step;
            end
          end
        end
        ST_SHOWN: begin
          if (frame_tick) r_blink <= w_blink_nxt;
        end
        default: r_state <= ST_HIDDEN;
      endcase
    end
  end

  assign w_ys = {1'b0, pos_y} + r_off;
  assign w_xs = {1'b0, pos_x};
  assign w_in = (r_state != ST_HIDDEN) && (w_ys >= c_y_top) && (w_ys < c_y_end) &&
                (w_xs >= c_x_lft) && (w_xs < c_x_end);
  assign w_addr = ADDR_W'(int'(r_row) * W + int'(r_col));

  assign w_fg  = (BLINK_FRAMES == 0 || r_blink < c_bf) ? FG_A : FG_B;
  assign w_pix = (r_vld[ROM_LAT] && !rom_data) ? w_fg : BG_COLOR;

  // region flag rides alongside the ROM so it lines up with rom_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in0  <= 1'b0;
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
      r_vld  <= '0;
      r_rgb  <= BG_COLOR;
      r_act  <= 1'b0;
    end else begin
      r_in0  <= w_in;
      r_row  <= w_ys - c_y_top;
      r_col  <= w_xs - c_x_lft;
      r_addr <= w_addr;
      r_vld  <= {r_vld[ROM_LAT-1:0], r_in0};
      r_rgb  <= w_pix;
      r_act  <= r_vld[ROM_LAT];
    end
  end

  assign rom_addr   = r_addr;
  assign ovl_r      = r_rgb[11:8];
  assign ovl_g      = r_rgb[7:4];
  assign ovl_b      = r_rgb[3:0];
  assign ovl_active = r_act;
  assign anim_done  = r_done;

endmodule
`default_nettype wire
